fifo_burst_reader: RTL



---
 rtl/fifo_rd_pkg.sv | 17 +
 rtl/fifo_burst_reader.sv | 129 ++++++++++++
 2 files changed

// File: rtl/fifo_rd_pkg.sv
// Shared types and helpers for the show-ahead FIFO burst reader.
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    FLUSH = 2'd2
  } state_e;

  // Residual burst length: never more than a full burst, never zero.
  function automatic int unsigned min_len(input int unsigned lvl, input int unsigned burst_len);
    int unsigned m;
    m = (lvl < burst_len) ? lvl : burst_len;
    return (m == 0) ? 32'd1 : m;
  endfunction

endpackage

// File: rtl/fifo_burst_reader.sv
// Drains a show-ahead FIFO in fixed bursts (or a timed-out residual flush)
// onto a valid/ready stream with a per-burst last marker.
module fifo_burst_reader
  import fifo_rd_pkg::*;
#(
  parameter int DWIDTH    = 12,
  parameter int AWIDTH    = 8,
  parameter int BURST_LEN = 16,
  parameter int TIMEOUT   = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DWIDTH-1:0] fifo_q,
  input  logic              fifo_rdempty,
  input  logic              fifo_rdfull,
  input  logic [AWIDTH-1:0] fifo_rdusedw,
  output logic              fifo_rdreq,
  output logic [DWIDTH-1:0] m_data,
  output logic              m_valid,
  output logic              m_last,
  input  logic              m_ready,
  output logic              busy,
  output logic [15:0]       burst_cnt
);

  localparam int LW = AWIDTH + 1;
  localparam int IW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [LW-1:0] BURST_LEN_L = LW'(BURST_LEN);
  localparam logic [IW-1:0] IDLE_LAST   = IW'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [LW-1:0]     len_q, len_d;
  logic [LW-1:0]     issued_q, issued_d;
  logic [IW-1:0]     idle_cnt_q, idle_cnt_d;
  logic [DWIDTH-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic [15:0]       bcnt_q, bcnt_d;
  logic [LW-1:0]     lvl;
  logic              xfer;

  // rdusedw wraps to 0 when the FIFO is completely full.
  assign lvl  = fifo_rdfull ? (LW'(1) << AWIDTH) : {1'b0, fifo_rdusedw};
  assign xfer = valid_q & m_ready;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    issued_d   = issued_q;
    idle_cnt_d = idle_cnt_q;
    data_d     = data_q;
    valid_d    = valid_q;
    last_d     = last_q;
    bcnt_d     = bcnt_q;
    fifo_rdreq = 1'b0;

    if (xfer) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end

    case (state_q)
      IDLE: begin
        issued_d = '0;
        if (lvl >= BURST_LEN_L) begin
          len_d      = BURST_LEN_L;
          idle_cnt_d = '0;
          state_d    = BURST;
        end else if (!fifo_rdempty) begin
          if (idle_cnt_q == IDLE_LAST) begin
            len_d      = LW'(min_len(32'(lvl), BURST_LEN));
            idle_cnt_d = '0;
            state_d    = FLUSH;
          end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
          end
        end else begin
          idle_cnt_d = '0;
        end
      end

      BURST, FLUSH: begin
        // Refill only when the output register is empty or emptying this cycle.
        fifo_rdreq = !fifo_rdempty && (issued_q < len_q) && (!valid_q || m_ready);
        if (fifo_rdreq) begin
          data_d   = fifo_q;
          valid_d  = 1'b1;
          last_d   = (issued_q == len_q - 1'b1);
          issued_d = issued_q + 1'b1;
        end
        if (xfer && last_q) begin
          bcnt_d  = bcnt_q + 1'b1;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      len_q      <= '0;
      issued_q   <= '0;
      idle_cnt_q <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      bcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      idle_cnt_q <= idle_cnt_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      bcnt_q     <= bcnt_d;
    end
  end

  assign m_data    = data_q;
  assign m_valid   = valid_q;
  assign m_last    = last_q;
  assign busy      = (state_q != IDLE);
  assign burst_cnt = bcnt_q;

endmodule
